// File: rtl/enc_2hot_pipe_pkg.sv
// enc_2hot_pipe_pkg: shared sizing helpers for the 2-hot pair encoder
package enc_2hot_pipe_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

    function automatic int pair_cnt(input int n);
        return n * (n - 1) / 2;
    endfunction

endpackage

// File: rtl/enc_2hot_detect.sv
// enc_2hot_detect: combinational lead/trail bit finder with 2-hot legality flag
module enc_2hot_detect #(
    parameter int N  = 5,
    parameter int LW = 3
) (
    input  logic [N-1:0]  data_i,
    output logic [LW-1:0] lead_o,
    output logic [LW-1:0] trail_o,
    output logic          err_o
);

    int cnt;

    // highest set bit wins lead, lowest set bit wins trail, popcount decides legality
    always_comb begin
        lead_o  = '0;
        trail_o = '0;
        cnt     = 0;
        for (int k = 0; k < N; k++)
            if (data_i[k]) begin
                lead_o = LW'(k);
                cnt    = cnt + 1;
            end
        for (int k = N - 1; k >= 0; k--)
            if (data_i[k]) trail_o = LW'(k);
        err_o = (cnt != 2);
    end

endmodule

// File: rtl/enc_2hot_pipe.sv
// enc_2hot_pipe: two-stage valid/ready pipeline ranking 2-hot words in colex order
module enc_2hot_pipe
    import enc_2hot_pipe_pkg::*;
#(
    parameter int N  = 5,
    parameter int W  = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [W-1:0]  out_idx,
    output logic          out_err,
    output logic          out_valid,
    input  logic          out_ready,
    input  logic          clr_cnt,
    output logic [CW-1:0] err_cnt
);

    localparam int LW = clog2(N);
    localparam int RW = 2 * LW + 1;
    localparam int NP = pair_cnt(N);

    if ((64'd1 << W) < NP) begin : g_w_check
        $error("enc_2hot_pipe: W too small for N*(N-1)/2 pair indices");
    end

    logic          rdy_q;
    logic          s1_valid_q, s1_valid_d;
    logic [LW-1:0] s1_lead_q, s1_lead_d;
    logic [LW-1:0] s1_trail_q, s1_trail_d;
    logic          s1_err_q, s1_err_d;
    logic          s2_valid_q, s2_valid_d;
    logic [W-1:0]  s2_idx_q, s2_idx_d;
    logic          s2_err_q, s2_err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] det_lead, det_trail;
    logic          det_err;
    logic          s2_load, s1_load, accept;
    logic [RW-1:0] li, rank;

    enc_2hot_detect #(.N(N), .LW(LW)) u_detect (
        .data_i  (in_data),
        .lead_o  (det_lead),
        .trail_o (det_trail),
        .err_o   (det_err)
    );

    assign s2_load   = !s2_valid_q || out_ready;
    assign s1_load   = !s1_valid_q || s2_load;
    assign in_ready  = rdy_q && s1_load;
    assign accept    = in_valid && in_ready;
    assign li        = RW'(s1_lead_q);
    assign rank      = ((li * (li - RW'(1))) >> 1) + RW'(s1_trail_q);
    assign out_valid = s2_valid_q;
    assign out_idx   = s2_idx_q;
    assign out_err   = s2_err_q;
    assign err_cnt   = cnt_q;

    // next state: stages hold unless the stage downstream frees up, counter clear beats increment
    always_comb begin
        s1_valid_d = s1_load ? accept : s1_valid_q;
        s1_lead_d  = accept ? det_lead : s1_lead_q;
        s1_trail_d = accept ? det_trail : s1_trail_q;
        s1_err_d   = accept ? det_err : s1_err_q;
        s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
        s2_idx_d   = (s2_load && s1_valid_q) ? (s1_err_q ? '0 : W'(rank)) : s2_idx_q;
        s2_err_d   = (s2_load && s1_valid_q) ? s1_err_q : s2_err_q;
        cnt_d      = clr_cnt ? '0 :
                     (s2_valid_q && out_ready && s2_err_q && cnt_q != {CW{1'b1}}) ? cnt_q + CW'(1) : cnt_q;
    end

    // state registers; in_ready is held low until the first edge after reset release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_q      <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_lead_q  <= '0;
            s1_trail_q <= '0;
            s1_err_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_idx_q   <= '0;
            s2_err_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            rdy_q      <= 1'b1;
            s1_valid_q <= s1_valid_d;
            s1_lead_q  <= s1_lead_d;
            s1_trail_q <= s1_trail_d;
            s1_err_q   <= s1_err_d;
            s2_valid_q <= s2_valid_d;
            s2_idx_q   <= s2_idx_d;
            s2_err_q   <= s2_err_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_enc_2hot_pipe.sv
// tb_enc_2hot_pipe: directed and randomised checks of the 2-hot pair encoder pipeline
module tb_enc_2hot_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic       clr_cnt = 1'b0;
    logic       in_ready, out_err, out_valid;
    logic [3:0] out_idx;
    logic [7:0] err_cnt;
    logic       in_ready2, out_err2, out_valid2;
    logic [3:0] out_idx2;
    logic [1:0] err_cnt2;

    int total = 0;
    int bad = 0;

    logic [4:0] leg [10] = '{5'b00011, 5'b00101, 5'b00110, 5'b01001, 5'b01010,
                             5'b01100, 5'b10001, 5'b10010, 5'b10100, 5'b11000};
    int         leg_idx [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    logic [4:0] ill [4] = '{5'b00000, 5'b00001, 5'b00111, 5'b11111};
    logic [4:0] bp [6] = '{5'b11000, 5'b00011, 5'b01100, 5'b01001, 5'b10100, 5'b00101};
    int         bp_idx [6] = '{9, 0, 5, 3, 8, 1};
    int         sat [5] = '{1, 2, 3, 3, 3};

    enc_2hot_pipe #(.N(5), .W(4), .CW(8)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_idx(out_idx), .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready),
        .clr_cnt(clr_cnt), .err_cnt(err_cnt)
    );

    enc_2hot_pipe #(.N(5), .W(4), .CW(2)) dut2 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready2),
        .out_idx(out_idx2), .out_err(out_err2), .out_valid(out_valid2), .out_ready(out_ready),
        .clr_cnt(clr_cnt), .err_cnt(err_cnt2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // colex reference: walk pairs (hi, lo) in order and count until the word matches
    function automatic logic [4:0] ref_enc(input logic [4:0] d);
        int r;
        ref_enc = 5'b10000;
        r = 0;
        for (int hi = 1; hi < 5; hi++)
            for (int lo = 0; lo < hi; lo++) begin
                if (d == ((5'b1 << hi) | (5'b1 << lo))) ref_enc = {1'b0, 4'(r)};
                r++;
            end
    endfunction

    initial begin
        int p, d, ecnt;
        logic [4:0] e, q[$];
        logic hold;
        logic [3:0] hidx;
        // reset state
        repeat (2) tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_idx", out_idx, 0);
        chk("rst_err", out_err, 0);
        chk("rst_cnt", err_cnt, 0);
        chk("rst_rdy", in_ready, 0);
        rst = 1'b0;
        #1;
        chk("rel_rdy0", in_ready, 0);
        tick();
        chk("rel_rdy1", in_ready, 1);
        // legal sweep, back to back
        for (int t = 0; t < 13; t++) begin
            in_valid = t < 10;
            in_data = t < 10 ? leg[t] : 5'b0;
            #1;
            if (t < 10) chk("s1_rdy", in_ready, 1);
            if (t >= 2 && t < 12) begin
                chk("s1_valid", out_valid, 1);
                chk("s1_idx", out_idx, leg_idx[t-2]);
                chk("s1_err", out_err, 0);
            end
            if (t == 12) chk("s1_drain", out_valid, 0);
            tick();
        end
        // illegal words
        for (int t = 0; t < 7; t++) begin
            in_valid = t < 4;
            in_data = t < 4 ? ill[t] : 5'b0;
            #1;
            if (t >= 2 && t < 6) begin
                chk("s2_valid", out_valid, 1);
                chk("s2_err", out_err, 1);
                chk("s2_idx", out_idx, 0);
            end
            chk("s2_cnt", err_cnt, t >= 2 ? t - 2 : 0);
            tick();
        end
        // backpressure
        p = 0;
        d = 0;
        for (int t = 0; t < 20; t++) begin
            in_valid = p < 6;
            in_data = p < 6 ? bp[p] : 5'b0;
            out_ready = t >= 5;
            #1;
            if (t >= 2 && t < 5) begin
                chk("s3_rdy", in_ready, 0);
                chk("s3_stable", out_idx, 9);
                chk("s3_valid", out_valid, 1);
            end
            if (out_valid && out_ready) begin
                if (d < 6) begin
                    chk("s3_idx", out_idx, bp_idx[d]);
                    chk("s3_err", out_err, 0);
                end
                d++;
            end
            if (in_valid && in_ready) p++;
            tick();
        end
        chk("s3_count", d, 6);
        // saturation on the CW=2 instance, clear wins over increment
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        for (int t = 0; t < 9; t++) begin
            in_valid = t < 6;
            in_data = 5'b0;
            clr_cnt = t == 7;
            #1;
            if (t >= 3 && t <= 7) chk("s4_sat", err_cnt2, sat[t-3]);
            if (t == 7) chk("s4_cnt8", err_cnt, 5);
            if (t == 8) begin
                chk("s4_clr2", err_cnt2, 0);
                chk("s4_clr8", err_cnt, 0);
            end
            tick();
        end
        clr_cnt = 1'b0;
        // asynchronous reset with both stages full
        in_valid = 1'b1;
        in_data = 5'b00000;
        tick();
        in_data = 5'b11000;
        tick();
        in_data = 5'b10001;
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("s5_pre_cnt", err_cnt, 1);
        chk("s5_pre_valid", out_valid, 1);
        chk("s5_pre_idx", out_idx, 9);
        rst = 1'b1;
        #1;
        chk("s5_valid", out_valid, 0);
        chk("s5_cnt", err_cnt, 0);
        chk("s5_idx", out_idx, 0);
        chk("s5_err", out_err, 0);
        chk("s5_rdy", in_ready, 0);
        tick();
        rst = 1'b0;
        tick();
        in_valid = 1'b1;
        in_data = 5'b10100;
        out_ready = 1'b1;
        #1;
        chk("s5_rdy1", in_ready, 1);
        tick();
        in_valid = 1'b0;
        #1;
        chk("s5_noreplay", out_valid, 0);
        tick();
        chk("s5_post_valid", out_valid, 1);
        chk("s5_post_idx", out_idx, 8);
        chk("s5_post_err", out_err, 0);
        tick();
        // random valid/ready traffic against the colex reference
        ecnt = 0;
        hold = 1'b0;
        hidx = '0;
        for (int c = 0; c < 3000; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data = $urandom_range(0, 1) ? leg[$urandom_range(0, 9)] : 5'($urandom);
            out_ready = $urandom_range(0, 3) != 0;
            #1;
            chk("r_x", 32'($isunknown({in_ready, out_idx, out_err, out_valid, err_cnt})), 0);
            chk("r_cnt", err_cnt, ecnt);
            if (hold) chk("r_hold", out_idx, hidx);
            hold = out_valid && !out_ready;
            hidx = out_idx;
            if (out_valid && out_ready) begin
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("r_idx", out_idx, e[3:0]);
                    chk("r_err", out_err, e[4]);
                    if (e[4] && ecnt < 255) ecnt++;
                end else chk("r_spurious", out_valid, 0);
            end
            if (in_valid && in_ready) q.push_back(ref_enc(in_data));
            tick();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
